pc_redirect_ctrl: RTL and testbench

//  Program-counter owner and redirect consumer for the 5-stage RV32 pipeline.
//  - Sinks the branch unit's taken flag (PcSel) and target (BrPC).
//  - Holds Cur_PC (fed back to the branch unit and to instruction memory).
//  - Applies stall/halt, inserts post-redirect bubbles, counts taken redirects.

---
 rtl/pc_redirect_ctrl.sv | 113 +++++++++++
 tb/tb_pc_redirect_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// PC owner for the 5-stage RV32 pipeline: applies redirects, stall/halt, post-redirect bubbles, taken count.
// Optional MISALIGN_TRAP_EN: a misaligned redirect target halts the core and sets Misalign instead of being taken.
module pc_redirect_ctrl #(
  parameter int PC_W      = 9,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PcSel,
  input  logic [31:0]      BrPC,
  input  logic             Stall,
  input  logic             Halt,
  output logic [PC_W-1:0]  Cur_PC,
  output logic             Flush,
  output logic             FetchValid,
  output logic             Halted,
  output logic [CNT_W-1:0] BrCnt,
  output logic             Misalign
);

  typedef enum logic [1:0] {RUN, BUBBLE, HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        bub_q, bub_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mis_q, mis_d;

  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   tgt;
  logic              tgt_bad;
  logic              unused_brpc;

  // Target is word aligned; upper bits beyond the PC width are dropped.
  assign pc_inc      = pc_q + PC_W'(4);
  assign tgt         = {BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc = ^{BrPC[31:PC_W], BrPC[1:0]};

`ifdef MISALIGN_TRAP_EN
  assign tgt_bad = |BrPC[1:0];
`else
  assign tgt_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bub_d   = bub_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    unique case (state_q)
      RUN: begin
        if (Halt) begin
          state_d = HALT;
        end else if (PcSel) begin
          if (tgt_bad) begin
            state_d = HALT;
            mis_d   = 1'b1;
          end else begin
            pc_d    = tgt;
            cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = BUBBLE;
            bub_d   = 3'(FLUSH_CYC - 1);
          end
        end else if (!Stall) begin
          pc_d = pc_inc;
        end
      end
      BUBBLE: begin
        // EX holds a squashed slot here, so PcSel is not looked at.
        if (Halt) begin
          state_d = HALT;
        end else begin
          if (!Stall) pc_d = pc_inc;
          if (bub_q == 3'd0) state_d = RUN;
          else               bub_d   = bub_q - 3'd1;
        end
      end
      HALT: ;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      bub_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bub_q   <= bub_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign Cur_PC     = pc_q;
  assign Flush      = (state_q == RUN) & PcSel & ~Halt;
  assign FetchValid = (state_q == RUN);
  assign Halted     = (state_q == HALT);
  assign BrCnt      = cnt_q;

`ifdef MISALIGN_TRAP_EN
  assign Misalign = mis_q;
`else
  assign Misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl (PC_W=9, FLUSH_CYC=2, CNT_W=4 so saturation is reachable).
module tb_pc_redirect_ctrl;
  localparam int PC_W = 9;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             PcSel = 1'b0;
  logic [31:0]      BrPC = '0;
  logic             Stall = 1'b0;
  logic             Halt = 1'b0;
  logic [PC_W-1:0]  Cur_PC;
  logic             Flush;
  logic             FetchValid;
  logic             Halted;
  logic [CNT_W-1:0] BrCnt;
  logic             Misalign;

  int errors = 0;
  int checks = 0;

  pc_redirect_ctrl #(.PC_W(PC_W), .FLUSH_CYC(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC), .Stall(Stall), .Halt(Halt),
    .Cur_PC(Cur_PC), .Flush(Flush), .FetchValid(FetchValid), .Halted(Halted),
    .BrCnt(BrCnt), .Misalign(Misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; PcSel = 1'b0; Stall = 1'b0; Halt = 1'b0; BrPC = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (Cur_PC !== 9'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", Cur_PC); end
    checks++; if ({FetchValid, Flush, Halted, Misalign} !== 4'b1000) begin errors++; $display("FAIL reset_flags got=%b exp=1000", {FetchValid, Flush, Halted, Misalign}); end
    checks++; if (BrCnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", BrCnt); end
  endtask

  task automatic test_free_run();
    logic [PC_W-1:0] exp_pc [3] = '{9'h004, 9'h008, 9'h00C};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Cur_PC !== exp_pc[i] || FetchValid !== 1'b1) begin errors++; $display("FAIL free_run[%0d] pc=%h fv=%b exp pc=%h fv=1", i, Cur_PC, FetchValid, exp_pc[i]); end
    end
    tick();
  endtask

  task automatic test_redirect();
    checks++; if (Cur_PC !== 9'h010) begin errors++; $display("FAIL redir_start got=%h exp=010", Cur_PC); end
    PcSel = 1'b1; BrPC = 32'h40;
    #1;
    checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL redir_flush got=%b exp=1", Flush); end
    tick();
    checks++; if (Cur_PC !== 9'h040 || FetchValid !== 1'b0 || BrCnt !== 4'd1) begin errors++; $display("FAIL redir_b0 pc=%h fv=%b cnt=%0d exp 040/0/1", Cur_PC, FetchValid, BrCnt); end
    BrPC = 32'h80;
    #1;
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL redir_bub_flush got=%b exp=0", Flush); end
    tick();
    PcSel = 1'b0;
    checks++; if (Cur_PC !== 9'h044 || FetchValid !== 1'b0 || BrCnt !== 4'd1) begin errors++; $display("FAIL redir_b1 pc=%h fv=%b cnt=%0d exp 044/0/1", Cur_PC, FetchValid, BrCnt); end
    tick();
    checks++; if (Cur_PC !== 9'h048 || FetchValid !== 1'b1) begin errors++; $display("FAIL redir_run pc=%h fv=%b exp 048/1", Cur_PC, FetchValid); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) tick();
    checks++; if (Cur_PC !== 9'h020) begin errors++; $display("FAIL stall_start got=%h exp=020", Cur_PC); end
    Stall = 1'b1; PcSel = 1'b1; BrPC = 32'h100;
    tick();
    PcSel = 1'b0;
    checks++; if (Cur_PC !== 9'h100) begin errors++; $display("FAIL stall_redir got=%h exp=100", Cur_PC); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Cur_PC !== 9'h100) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=100", i, Cur_PC); end
    end
    Stall = 1'b0;
    tick();
    checks++; if (Cur_PC !== 9'h104 || FetchValid !== 1'b1) begin errors++; $display("FAIL stall_release pc=%h fv=%b exp 104/1", Cur_PC, FetchValid); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (12) tick();
    Halt = 1'b1; PcSel = 1'b1; BrPC = 32'h80;
    #1;
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL halt_flush got=%b exp=0", Flush); end
    tick();
    Halt = 1'b0; PcSel = 1'b0;
    checks++; if (Halted !== 1'b1 || Cur_PC !== 9'h030 || FetchValid !== 1'b0) begin errors++; $display("FAIL halt_enter h=%b pc=%h fv=%b exp 1/030/0", Halted, Cur_PC, FetchValid); end
    PcSel = 1'b1; BrPC = 32'h100;
    #1;
    checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL halt_ign_flush got=%b exp=0", Flush); end
    tick(); PcSel = 1'b0; Stall = 1'b1; tick(); Stall = 1'b0; tick();
    checks++; if (Halted !== 1'b1 || Cur_PC !== 9'h030 || BrCnt !== 4'd0) begin errors++; $display("FAIL halt_frozen h=%b pc=%h cnt=%0d exp 1/030/0", Halted, Cur_PC, BrCnt); end
    do_reset();
    checks++; if (Halted !== 1'b0 || Cur_PC !== 9'h000 || FetchValid !== 1'b1) begin errors++; $display("FAIL halt_reset h=%b pc=%h fv=%b exp 0/000/1", Halted, Cur_PC, FetchValid); end
    // Halt arriving during the bubble window
    PcSel = 1'b1; BrPC = 32'h80;
    tick();
    PcSel = 1'b0; Halt = 1'b1;
    tick();
    Halt = 1'b0;
    tick();
    checks++; if (Halted !== 1'b1 || Cur_PC !== 9'h080) begin errors++; $display("FAIL halt_bubble h=%b pc=%h exp 1/080", Halted, Cur_PC); end
  endtask

  task automatic test_wrap();
    do_reset();
    PcSel = 1'b1; BrPC = 32'h1F0;
    tick();
    PcSel = 1'b0;
    tick(); tick();
    checks++; if (Cur_PC !== 9'h1F8 || FetchValid !== 1'b1) begin errors++; $display("FAIL wrap_start pc=%h fv=%b exp 1F8/1", Cur_PC, FetchValid); end
    tick();
    checks++; if (Cur_PC !== 9'h1FC) begin errors++; $display("FAIL wrap_1fc got=%h exp=1FC", Cur_PC); end
    tick();
    checks++; if (Cur_PC !== 9'h000) begin errors++; $display("FAIL wrap_000 got=%h exp=000", Cur_PC); end
    PcSel = 1'b1; BrPC = 32'hFFFF_F10C;
    tick();
    PcSel = 1'b0;
    checks++; if (Cur_PC !== 9'h10C || BrCnt !== 4'd2) begin errors++; $display("FAIL wrap_trunc pc=%h cnt=%0d exp 10C/2", Cur_PC, BrCnt); end
  endtask

  task automatic test_misalign();
    do_reset();
    tick(); tick();
    PcSel = 1'b1; BrPC = 32'h042;
    #1;
    checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL mis_flush got=%b exp=1", Flush); end
    tick();
    PcSel = 1'b0;
`ifdef MISALIGN_TRAP_EN
    checks++; if (Misalign !== 1'b1 || Halted !== 1'b1 || Cur_PC !== 9'h008 || BrCnt !== 4'd0) begin errors++; $display("FAIL mis_trap m=%b h=%b pc=%h cnt=%0d exp 1/1/008/0", Misalign, Halted, Cur_PC, BrCnt); end
`else
    checks++; if (Misalign !== 1'b0 || Halted !== 1'b0 || Cur_PC !== 9'h040 || BrCnt !== 4'd1) begin errors++; $display("FAIL mis_force m=%b h=%b pc=%h cnt=%0d exp 0/0/040/1", Misalign, Halted, Cur_PC, BrCnt); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 19; i++) begin
      PcSel = 1'b1; BrPC = 32'h100;
      tick();
      PcSel = 1'b0;
      if (i == 14 || i == 15 || i == 19) begin
        checks++; if (BrCnt !== ((i > 15) ? 4'd15 : 4'(i))) begin errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, BrCnt, (i > 15) ? 15 : i); end
      end
      tick(); tick();
    end
  endtask

  task automatic test_reset_mid();
    PcSel = 1'b1; BrPC = 32'h0C0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; PcSel = 1'b0;
    checks++; if (Cur_PC !== 9'h000 || FetchValid !== 1'b1 || Halted !== 1'b0 || BrCnt !== 4'd0 || Misalign !== 1'b0) begin errors++; $display("FAIL reset_mid pc=%h fv=%b h=%b cnt=%0d m=%b exp 000/1/0/0/0", Cur_PC, FetchValid, Halted, BrCnt, Misalign); end
    tick();
    checks++; if (Cur_PC !== 9'h004) begin errors++; $display("FAIL reset_mid_run got=%h exp=004", Cur_PC); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_redirect();
    test_stall();
    test_halt();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
